// File: rtl/ofifo_pkg.sv
// Shared defaults for the output FIFO: array geometry, queue depth and pointer sizing.
package ofifo_pkg;

    localparam int COL         = 16;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int OFIFO_PTR_W = ptr_w(OFIFO_DEPTH);

endpackage

// File: rtl/ofifo_fifo_col.sv
// Single-column circular queue, first-word-fall-through head, 0-cycle push-to-head.
// Push into a full queue is taken only alongside a pop; otherwise it is dropped and flagged.
module fifo_col
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic               drop
);

    localparam int PW = ptr_w(depth);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot this push lands in.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = mem[rd_ptr];

    // Cleared on reset so the fall-through head never presents unwritten data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: col independent column queues popped as whole rows; head row falls through.
// Flags come from registered counts only; writes to a full column without a pop drop and set sticky o_overflow.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*psum_bw-1:0] in,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0] full_c;
    logic [col-1:0] empty_c;
    logic [col-1:0] drop_c;
    logic           pop;

    assign o_valid = ~|empty_c;
    assign o_full  = |full_c;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar c = 0; c < col; c++) begin : gen_col
        fifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .push  (wr[c]),
            .pop   (pop),
            .din   (in[c*psum_bw +: psum_bw]),
            .dout  (out[c*psum_bw +: psum_bw]),
            .full  (full_c[c]),
            .empty (empty_c[c]),
            .drop  (drop_c[c])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       o_overflow <= 1'b0;
        else if (|drop_c) o_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo with per-column scoreboard queues and immediate-assertion checks.
module tb_ofifo;

    localparam int C = 16;
    localparam int W = 16;
    localparam int D = 64;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [C-1:0]   wr    = '0;
    logic [C*W-1:0] in    = '0;
    logic           rd    = 1'b0;
    logic [C*W-1:0] out;
    logic           o_valid, o_full, o_ready, o_overflow;

    logic [W-1:0] q [C][$];
    logic         ovf_m = 1'b0;
    int           checks = 0;
    int           errors = 0;

    ofifo #(.col(C), .psum_bw(W), .depth(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (in),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        for (int c = 0; c < C; c++) if (q[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < C; c++) if (q[c].size() == D) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [C*W-1:0] make_row(input int base);
        logic [C*W-1:0] r;
        for (int c = 0; c < C; c++) r[c*W +: W] = W'(base + c);
        return r;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'(m_valid()));
        chk({tag, "_full"}, 32'(o_full), 32'(m_full()));
        chk({tag, "_ready"}, 32'(o_ready), 32'(!m_full()));
        chk({tag, "_ovf"}, 32'(o_overflow), 32'(ovf_m));
        for (int c = 0; c < C; c++)
            if (q[c].size() != 0) chk({tag, "_head"}, 32'(out[c*W +: W]), 32'(q[c][0]));
    endtask

    // One clock: drive at negedge, score the popped row before the edge, check after it.
    task automatic cyc(input string tag, input logic [C-1:0] w, input logic [C*W-1:0] d, input logic r);
        logic [W-1:0] e;
        @(negedge clk);
        wr = w; in = d; rd = r;
        #1;
        if (r && m_valid()) begin
            for (int c = 0; c < C; c++) begin
                e = q[c].pop_front();
                chk({tag, "_pop"}, 32'(out[c*W +: W]), 32'(e));
            end
        end
        for (int c = 0; c < C; c++) begin
            if (w[c]) begin
                if (q[c].size() < D) q[c].push_back(d[c*W +: W]);
                else ovf_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        wr = '0; rd = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int c = 0; c < C; c++) q[c].delete();
        ovf_m = 1'b0;
        check_state(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [C*W-1:0] row;

        // Reset is low from time 0; flags must already be at their reset values.
        #1;
        check_state("rst_async");
        repeat (2) @(negedge clk);
        check_state("rst_hold");
        reset = 1'b1;

        // One column alone does not make a row; the rest completes it.
        row = '0; row[15:0] = 16'h1234;
        cyc("first_wr", 16'h0001, row, 1'b0);
        chk("first_wr_valid0", 32'(o_valid), 32'd0);
        cyc("rest_wr", 16'hFFFE, make_row(16'h0500), 1'b0);
        chk("rest_wr_valid1", 32'(o_valid), 32'd1);
        chk("rest_wr_col0", 32'(out[15:0]), 32'h1234);
        cyc("drain0", '0, '0, 1'b1);
        cyc("rd_empty", '0, '0, 1'b1);

        // Staggered fill, two rows deep.
        for (int c = 0; c < C; c++) cyc("stag_a", C'(1) << c, make_row(100), 1'b0);
        for (int c = 0; c < C; c++) cyc("stag_b", C'(1) << c, make_row(200), 1'b0);
        cyc("stag_pop", '0, '0, 1'b1);
        cyc("stag_pop", '0, '0, 1'b1);
        chk("stag_valid_fall", 32'(o_valid), 32'd0);

        // Fill every column to depth, then overflow column 3.
        for (int i = 0; i < D; i++) cyc("fill", '1, make_row(i * 32), 1'b0);
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_ready", 32'(o_ready), 32'd0);
        row = '0; row[3*W +: W] = 16'hDEAD;
        cyc("ovf_wr", 16'h0008, row, 1'b0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        chk("ovf_col3_head", 32'(out[3*W +: W]), 32'(3));
        cyc("ovf_sticky", '0, '0, 1'b0);

        // Full queues: push and pop together is accepted, count holds at depth.
        do_reset("rst_full");
        for (int i = 0; i < D; i++) cyc("refill", '1, make_row(i * 32 + 7), 1'b0);
        row = '0;
        for (int c = 0; c < C; c++) row[c*W +: W] = 16'hBEEF;
        cyc("full_pp", '1, row, 1'b1);
        chk("full_pp_ovf", 32'(o_overflow), 32'd0);
        chk("full_pp_full", 32'(o_full), 32'd1);
        for (int i = 0; i < D; i++) cyc("full_drain", '0, '0, 1'b1);
        chk("full_drain_empty", 32'(o_valid), 32'd0);

        // Wrap: steady occupancy of 4 with continuous push/pop.
        do_reset("rst_wrap");
        for (int i = 0; i < 4; i++) cyc("wrap_pre", '1, make_row(i), 1'b0);
        for (int i = 0; i < 200; i++) begin
            for (int c = 0; c < C; c++) row[c*W +: W] = W'($urandom);
            cyc("wrap", '1, row, 1'b1);
        end
        for (int i = 0; i < 4; i++) cyc("wrap_drain", '0, '0, 1'b1);

        // Mid-stream reset drops o_valid without a clock edge.
        for (int i = 0; i < 10; i++) cyc("pre_rst", '1, make_row(1000 + i * 16), 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        for (int c = 0; c < C; c++) q[c].delete();
        ovf_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc("post_rst", '1, make_row(16'h5550), 1'b0);
        chk("post_rst_col0", 32'(out[15:0]), 32'h5550);
        cyc("post_rst_pop", '0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 Parameter col, default 16: number of array columns, and so the number of independent column queues.
REQ-002 Parameter psum_bw, default 16: partial-sum width per column.
REQ-003 Parameter depth, default 64: entries per column queue; a power of two, at least 2.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 wr  input  col: per-column write strobe from MAC array column outputs; bit c writes column c.
REQ-007 in  input  col*psum_bw: column c data at bits [c*psum_bw +: psum_bw].
REQ-008 rd  input  1: pop one full row (one entry from every column).
REQ-009 out  output  col*psum_bw: head row, column c at bits [c*psum_bw +: psum_bw].
REQ-010 o_valid  output  1: every column queue is non-empty; this drives the core's ofifo_valid.
REQ-011 o_full  output  1: at least one column queue is full.
REQ-012 o_ready  output  1: no column queue is full (equals ~o_full).
REQ-013 o_overflow  output  1: sticky error flag, set by any dropped write.

Function
REQ-014 Each column SHALL be an independent circular queue with its own write pointer, read pointer and occupancy count (0..depth).
REQ-015 Columns SHALL be written asynchronously to one another: column c pushes in[c] on a clock edge where wr[c]=1 and the write is accepted.
REQ-016 A row pop SHALL be accepted only when rd=1 and o_valid=1; it advances every column's read pointer by one on that edge.
REQ-017 rd while o_valid=0 SHALL be ignored: no pointer change and no error.
REQ-018 out SHALL be first-word-fall-through: combinational from each column's head entry, with zero cycles from push to visibility once o_valid rises.
REQ-019 out SHALL hold the previous head value when o_valid=0 (don't-care for checking) and must never show unwritten X.
REQ-020 o_valid, o_full and o_ready SHALL be combinational functions of the registered counts only, never of wr or rd.
REQ-021 Write to a full column (count=depth) SHALL be accepted only if a row pop is accepted on the same edge; the count then stays at depth.
REQ-022 A write to a full column without a same-cycle pop SHALL be dropped and SHALL set o_overflow on that edge.
REQ-023 o_overflow, once set, SHALL hold until reset.
REQ-024 Simultaneous accepted push and pop on a non-full column SHALL leave its count unchanged and advance both pointers.
REQ-025 Pointers SHALL wrap from depth-1 to 0 with no lost or duplicated entry.
REQ-026 Data SHALL pass through unmodified: no arithmetic and no width change.

Reset
REQ-027 While reset=0, all pointers and counts SHALL be 0, o_overflow 0, o_valid 0, o_full 0 and o_ready 1, all asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-029 The first write SHALL be honoured on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package SHALL hold the defaults COL=16, PSUM_BW=16 and OFIFO_DEPTH=64, plus pointer width clog2(depth).
REQ-031 One sub-module, fifo_col (single-column queue: push, pop, count, full, empty), SHALL be instantiated col times via generate.
REQ-032 The top level SHALL contain only the AND/OR reductions of the column flags and the overflow register.

Verification
REQ-033 Reset, then wr=16'h0001 with in[15:0]=16'h1234 for 1 cycle -> o_valid=0; then wr=16'hFFFE for 1 cycle -> o_valid=1, out column 0 = 16'h1234.
REQ-034 Staggered fill: column c written at cycle c with value c+100, c=0..15 -> o_valid rises only after column 15 is written; rd -> out rows match in order; o_valid falls after the last pop.
REQ-035 Fill every column to 64 -> o_full=1, o_ready=0; a 65th write on column 3 with no rd -> o_overflow=1 and column 3 head unchanged.
REQ-036 Full queues, rd=1 together with wr=all ones and in=16'hBEEF in every column -> no overflow, count stays 64, the 64th pop returns 16'hBEEF in every column.
REQ-037 Wrap: 200 cycles of continuous push and pop at depth 4 occupancy -> output sequence equals input sequence, o_full never asserted.
REQ-038 Drive reset=0 mid-stream with 10 entries queued -> o_valid drops immediately with no clock edge; after release the first new write is the new head.
